// File: rtl/fifo_reader_pkg.sv
// Shared constants and state type for the transaction-layer FIFO read side.
package fifo_reader_pkg;

  localparam int unsigned DEF_FIFO_DEPTH            = 8;
  localparam int unsigned DEF_FIFO_WORD_SIZE        = 10;
  localparam int unsigned DEF_ALMOST_FULL_THRESHOLD = 6;
  localparam int unsigned OBUF_DEPTH                = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_reader_obuf.sv
// Two-entry in-order output buffer; head entry drives dout directly from a register.
module fifo_reader_obuf
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_FIFO_WORD_SIZE
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       occ_q;
  logic             pop_ok;

  assign pop_ok = pop && (occ_q != 2'd0);
  assign dout   = head_q;
  assign occ    = occ_q;

  // A push into a full buffer without a pop cannot occur: the reader never
  // issues a FIFO pop unless a slot is guaranteed to be free on arrival.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      unique case (occ_q)
        2'd0: begin
          if (push) begin
            head_q <= din;
            occ_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop_ok) begin
            head_q <= din;
          end else if (push) begin
            tail_q <= din;
            occ_q  <= 2'd2;
          end else if (pop_ok) begin
            occ_q  <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_ok) begin
            head_q <= tail_q;
            if (push) tail_q <= din;
            else      occ_q  <= 2'd1;
          end
        end
        default: occ_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side controller: mirrors occupancy from pushes, issues pops and
// delivers the FIFO's registered read data through a 2-entry valid/ready buffer.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH            = DEF_FIFO_DEPTH,
  parameter int unsigned FIFO_WORD_SIZE        = DEF_FIFO_WORD_SIZE,
  parameter int unsigned FIFO_PTR_SIZE         = $clog2(FIFO_DEPTH),
  parameter int unsigned ALMOST_FULL_THRESHOLD = DEF_ALMOST_FULL_THRESHOLD
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      enable,
  input  logic                      fifo_push,
  input  logic [FIFO_WORD_SIZE-1:0] fifo_data,
  output logic                      fifo_rd_en,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      pause,
  output logic                      idle,
  output logic                      error_flag
);

  localparam int unsigned CNT_W = FIFO_PTR_SIZE + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(ALMOST_FULL_THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  rd_state_t        state_q;
  rd_state_t        state_d;
  logic [CNT_W-1:0] count_q;
  logic             inflight_q;
  logic             err_q;
  logic [1:0]       occ;
  logic             pop_out;
  logic [2:0]       outstanding;

  assign pop_out     = valid_out && ready_in;
  // Words held or arriving after this edge; a new pop is allowed only if a slot remains.
  assign outstanding = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_out};
  assign fifo_rd_en  = (state_q == ST_ACTIVE) && (count_q != '0) && (outstanding < 3'd2);

  assign valid_out  = (occ != 2'd0);
  assign pause      = (count_q >= CNT_THR);
  assign idle       = (state_q == ST_IDLE);
  assign error_flag = err_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (enable) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)                          state_d = ST_ACTIVE;
        else if (!inflight_q && occ == 2'd0) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // A push into a full FIFO with no concurrent pop is lost; count saturates.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (fifo_push && !fifo_rd_en) begin
        if (count_q == CNT_FULL) err_q   <= 1'b1;
        else                     count_q <= count_q + CNT_ONE;
      end else if (!fifo_push && fifo_rd_en) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  fifo_reader_obuf #(
    .WIDTH (FIFO_WORD_SIZE)
  ) u_obuf (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (inflight_q),
    .din     (fifo_data),
    .pop     (pop_out),
    .dout    (data_out),
    .occ     (occ)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural FIFO + scoreboard queue, directed scenarios then random traffic.
module tb_fifo_reader;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = 10;
  localparam int unsigned THR   = 6;

  logic         clk = 1'b0;
  logic         reset_L, enable, fifo_push, ready_in;
  logic [W-1:0] push_word, fifo_data, data_out;
  logic         fifo_rd_en, valid_out, pause, idle, error_flag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_cnt = 0;
  int outstanding = 0;
  bit exp_err = 1'b0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int beat_cyc[$];

  fifo_reader #(
    .FIFO_DEPTH            (DEPTH),
    .FIFO_WORD_SIZE        (W),
    .ALMOST_FULL_THRESHOLD (THR)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .enable     (enable),
    .fifo_push  (fifo_push),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .pause      (pause),
    .idle       (idle),
    .error_flag (error_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic got, input logic exp);
    check(name, 32'(got), 32'(exp));
  endtask

  // Behavioural FIFO: registered read data, drops pushes when full; accepted words go to the scoreboard.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fifo_q.delete();
      exp_q.delete();
      fifo_data   <= '0;
      exp_err     = 1'b0;
      outstanding = 0;
    end else begin
      int sz;
      sz = fifo_q.size();
      cyc++;
      if (valid_out && ready_in) outstanding--;
      if (fifo_rd_en) begin
        rd_cnt++;
        if (sz != 0) begin
          fifo_data <= fifo_q.pop_front();
          outstanding++;
        end
      end
      if (fifo_push) begin
        if (sz < int'(DEPTH) || fifo_rd_en) begin
          fifo_q.push_back(push_word);
          exp_q.push_back(push_word);
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  end

  // Monitor: sampled mid-cycle, pops the scoreboard on every transfer.
  always @(negedge clk) begin
    if (reset_L) begin
      checkb("pause", pause, fifo_q.size() >= int'(THR));
      checkb("error_flag", error_flag, exp_err);
      checkb("rd_from_empty", fifo_rd_en && (fifo_q.size() == 0), 1'b0);
      checkb("issue_window",
             (outstanding + int'(fifo_rd_en) - int'(valid_out && ready_in)) <= 2, 1'b1);
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(data_out), 32'hFFFF_FFFF);
        end else begin
          check("beat_data", 32'(data_out), 32'(exp_q.pop_front()));
          beat_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [W-1:0] w);
    fifo_push = 1'b1;
    push_word = w;
    tick();
    fifo_push = 1'b0;
  endtask

  // Waits for n beats counted from index start; reports last-first cycle distance.
  task automatic wait_beats(input string name, input int start, input int n, input int limit,
                            input int exp_span);
    int k = 0;
    while (beat_cyc.size() < start + n && k < limit) begin
      tick();
      k++;
    end
    check({name, "_count"}, 32'(beat_cyc.size() - start), 32'(n));
    if (beat_cyc.size() >= start + n)
      check({name, "_span"}, 32'(beat_cyc[start+n-1] - beat_cyc[start]), 32'(exp_span));
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while (!idle && k < limit) begin
      tick();
      k++;
    end
    checkb(name, idle, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkb({tag, "_rd_en"}, fifo_rd_en, 1'b0);
    checkb({tag, "_valid"}, valid_out, 1'b0);
    check({tag, "_data"}, 32'(data_out), 32'd0);
    checkb({tag, "_pause"}, pause, 1'b0);
    checkb({tag, "_idle"}, idle, 1'b1);
    checkb({tag, "_err"}, error_flag, 1'b0);
  endtask

  initial begin
    int start;
    int base;
    reset_L   = 1'b0;
    enable    = 1'b0;
    fifo_push = 1'b0;
    ready_in  = 1'b0;
    push_word = '0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    tick();

    // Single word latency
    enable   = 1'b1;
    ready_in = 1'b1;
    tick();
    tick();
    push1(10'h155);
    checkb("single_rd_en_c1", fifo_rd_en, 1'b1);
    tick();
    checkb("single_valid_c2", valid_out, 1'b0);
    tick();
    checkb("single_valid_c3", valid_out, 1'b1);
    check("single_data_c3", 32'(data_out), 32'h155);
    checkb("single_not_idle", idle, 1'b0);
    tick();

    // Back-to-back burst at full throughput
    start = beat_cyc.size();
    for (int i = 1; i <= 8; i++) push1(W'(i));
    wait_beats("burst", start, 8, 30, 7);
    checkb("burst_err", error_flag, 1'b0);

    // Backpressure: only two words leave the FIFO
    ready_in = 1'b0;
    base  = rd_cnt;
    start = beat_cyc.size();
    for (int i = 1; i <= 5; i++) push1(W'(100 + i));
    repeat (6) tick();
    check("bp_rd_pulses", 32'(rd_cnt - base), 32'd2);
    checkb("bp_rd_en_low", fifo_rd_en, 1'b0);
    checkb("bp_valid", valid_out, 1'b1);
    check("bp_head", 32'(data_out), 32'd101);
    ready_in = 1'b1;
    wait_beats("bp", start, 5, 30, 4);

    // Overflow with popping disabled
    enable = 1'b0;
    wait_idle("ovf_idle", 10);
    for (int i = 1; i <= 8; i++) push1(W'(200 + i));
    checkb("ovf_err_at8", error_flag, 1'b0);
    checkb("ovf_pause_at8", pause, 1'b1);
    push1(W'(209));
    checkb("ovf_err_at9", error_flag, 1'b1);
    checkb("ovf_pause_at9", pause, 1'b1);
    enable = 1'b1;
    wait_drain("ovf_drain", 40);

    // Drain with one word in flight and one buffered
    ready_in = 1'b0;
    tick();
    base = rd_cnt;
    for (int i = 0; i < 3; i++) push1(W'(300 + i));
    enable = 1'b0;
    checkb("drain_rd_en", fifo_rd_en, 1'b0);
    tick();
    checkb("drain_not_idle", idle, 1'b0);
    ready_in = 1'b1;
    wait_idle("drain_idle", 20);
    check("drain_rd_pulses", 32'(rd_cnt - base), 32'd2);
    check("drain_left", 32'(exp_q.size()), 32'd1);

    // Async reset in the middle of a burst
    enable = 1'b1;
    for (int i = 0; i < 4; i++) push1(W'(400 + i));
    fifo_push = 1'b1;
    push_word = W'(404);
    @(posedge clk);
    #3;
    reset_L   = 1'b0;
    fifo_push = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    tick();
    tick();
    start = beat_cyc.size();
    push1(10'h3AA);
    push1(10'h055);
    wait_beats("post_reset", start, 2, 20, 1);
    wait_drain("post_reset_drain", 10);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      ready_in  = ($urandom_range(0, 3) != 0);
      fifo_push = ($urandom_range(0, 1) == 1) && (fifo_q.size() < int'(DEPTH));
      push_word = W'($urandom_range(0, 1023));
      tick();
    end
    fifo_push = 1'b0;
    enable    = 1'b1;
    ready_in  = 1'b1;
    wait_drain("random_drain", 100);
    checkb("random_err", error_flag, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
